uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single TX path of the UART core (tx_data / tx_wr / tx_busy) between NREQ byte-producing requesters. Round-robin arbitration, with an optional per-requester lock that keeps multi-byte messages contiguous. It sequences the core's tx_wr pulse and tx_busy handshake, and flags a sticky error if the core never accepts a byte. It sits between firmware-visible TX sources (CPU peripheral port, debug/log engine, etc.) and the uart core instance.

Parameters:
NREQ, 4, number of requesters (2..8)
START_TIMEOUT, 16, max cycles to wait for tx_busy to rise after the tx_wr pulse
IDX_W, 2, width of grant index; must be >= clog2(NREQ)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester byte-available, level
req_lock  input  NREQ  per-requester hold-grant-after-this-byte, sampled with req_valid
req_data  input  8*NREQ  packed bytes, requester i at [8*i+7:8*i]
req_ack  output  NREQ  one-cycle pulse: requester's byte consumed
grant  output  NREQ  one-hot current/last owner
tx_data  output  8  byte to uart core
tx_wr  output  1  one-cycle write strobe to uart core
tx_busy  input  1  uart core transmitting
busy  output  1  arbiter not in IDLE
err_timeout  output  1  sticky: core failed to raise tx_busy
err_clr  input  1  clears err_timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; tx_data=0; tx_wr=0; req_ack=0; grant=0; rr pointer=NREQ-1; lock=0; err_timeout=0; timeout counter=0. All outputs are registered.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE, with tx_busy=0 and any req_valid=1:
  - Select winner. If lock=1 and req_valid[owner]=1, the owner wins. Otherwise lock clears and the winner is the first valid index scanning owner+1, owner+2, ... mod NREQ.
  - On the clock edge: tx_data <= winner byte; grant <= onehot(winner); req_ack[winner] pulses 1 cycle; lock <= req_lock[winner]; go to LOAD.
- IDLE with tx_busy=1 (core busy from elsewhere or a stale transfer): no grant; stay in IDLE.
- LOAD: tx_wr=1 for exactly this cycle; tx_data is stable; counter cleared; go to WAIT_START.
- WAIT_START:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise increment counter. When counter reaches START_TIMEOUT-1 without tx_busy: err_timeout <= 1, lock <= 0, go to IDLE. The byte is dropped, with no retry.
- WAIT_DONE: tx_busy=0 -> IDLE. There is no timeout here, because frame length is set by baud.
- Latency: req_valid seen in IDLE -> req_ack on the next edge; tx_wr 1 cycle later. Minimum 2 idle cycles between bytes (WAIT_DONE->IDLE->LOAD).
- tx_wr is never asserted outside LOAD. req_ack is at most one-hot and at most one pulse per transfer.
- Requester protocol: hold req_valid/req_data until req_ack. A requester that deasserts req_valid before ack loses its slot; no error.
- Lock release cases:
  - Owner presents a byte with req_lock=0.
  - Owner has req_valid=0 when arbitration is evaluated in IDLE.
  - A timeout occurs.
- A locked owner can starve others; this is the intended behaviour.
- err_clr=1 clears err_timeout on the next edge. If a timeout and err_clr occur in the same cycle, set wins.
- grant holds the last owner after the transfer completes (for status reads); it is only updated at arbitration.
- Indices >= NREQ do not exist; the rr pointer wraps mod NREQ, not mod 2^IDX_W.

Test Plan:
- Single request: req_valid=4'b0100, data[23:16]=8'hA5 -> req_ack=4'b0100 one cycle; tx_wr pulse 1 cycle later with tx_data=8'hA5; model raises tx_busy for 10 cycles; arbiter returns to IDLE; busy=0.
- Round-robin: all four valid continuously after reset (pointer=3) -> service order 0,1,2,3,0; grant one-hot each time; exactly one tx_wr per byte.
- Lock: requester 1 sends 3 bytes with req_lock=1,1,0 while requester 2 stays valid -> bytes 1,1,1 contiguous, then requester 2 served.
- Timeout: model never raises tx_busy -> err_timeout=1 exactly START_TIMEOUT cycles after the LOAD cycle; FSM returns to IDLE; next request still served; err_clr clears the flag; simultaneous set and clear leaves err_timeout=1.
- Async reset mid-WAIT_DONE: drive rst=0 between clock edges -> all outputs 0 immediately; after release, pending requests are re-arbitrated starting from index 0.
- Core busy at idle: tx_busy=1 with req_valid pending -> no req_ack or tx_wr until tx_busy=0, then a normal transfer.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART core TX path (tx_data / tx_wr / tx_busy) between NREQ
//   byte producers. Round-robin arbitration with an optional per-requester
//   lock that keeps multi-byte messages contiguous. Flags a sticky error if
//   the core never raises tx_busy after a write strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   req_valid    per-requester byte available (level)
//   req_lock     per-requester keep-grant-after-this-byte, sampled with req_valid
//   req_data     packed bytes, requester i at [8*i+7:8*i]
//   req_ack      one-cycle pulse: the requester's byte was taken
//   grant        one-hot current/last owner (updated only at arbitration)
//   tx_data      byte to the UART core
//   tx_wr        one-cycle write strobe to the UART core
//   tx_busy      UART core is transmitting
//   busy         arbiter is not idle
//   err_timeout  sticky: core failed to raise tx_busy in time
//   err_clr      clears err_timeout (a simultaneous timeout wins)
module uart_tx_arbiter #(
   parameter int unsigned NREQ          = 4,
   parameter int unsigned START_TIMEOUT = 16,
   parameter int unsigned IDX_W         = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ-1:0]     req_lock,
   input  logic [8*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]     req_ack,
   output logic [NREQ-1:0]     grant,
   output logic [7:0]          tx_data,
   output logic                tx_wr,
   input  logic                tx_busy,
   output logic                busy,
   output logic                err_timeout,
   input  logic                err_clr
);

   localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

   state_t            state, state_d;
   logic [IDX_W-1:0]  ptr, ptr_d;
   logic              lock, lock_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [7:0]        tx_data_d;
   logic [NREQ-1:0]   grant_d, ack_d;
   logic              wr_d, err_d;
   logic [IDX_W-1:0]  rr_win, win;

   logic [7:0] req_byte [NREQ];
   for (genvar g = 0; g < NREQ; g++) begin : g_byte
      assign req_byte[g] = req_data[8*g +: 8];
   end

   // Successor index that wraps at NREQ rather than at 2**IDX_W.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      return (i == IDX_W'(NREQ - 1)) ? '0 : i + IDX_W'(1);
   endfunction

   // First valid requester scanning ptr+1, ptr+2, ... (ptr itself last).
   always_comb begin
      logic [IDX_W-1:0] cand;
      logic             found;
      cand   = ptr;
      found  = 1'b0;
      rr_win = ptr;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = next_idx(cand);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            rr_win = cand;
         end
      end
   end

   assign win = (lock && req_valid[ptr]) ? ptr : rr_win;

   always_comb begin
      state_d   = state;
      ptr_d     = ptr;
      lock_d    = lock;
      cnt_d     = cnt;
      tx_data_d = tx_data;
      grant_d   = grant;
      ack_d     = '0;
      wr_d      = 1'b0;
      err_d     = err_timeout;

      case (state)
         IDLE: begin
            // A lock whose owner has nothing to send is dropped here.
            if (lock && !req_valid[ptr]) lock_d = 1'b0;
            if (!tx_busy && (|req_valid)) begin
               tx_data_d = req_byte[win];
               grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
               ack_d     = {{(NREQ-1){1'b0}}, 1'b1} << win;
               lock_d    = req_lock[win];
               ptr_d     = win;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            wr_d    = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               lock_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Clear only when no timeout is being raised this cycle.
      if (err_clr && !(state == WAIT_START && !tx_busy &&
                       cnt == CNT_W'(START_TIMEOUT - 1)))
         err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ptr         <= IDX_W'(NREQ - 1);
         lock        <= 1'b0;
         cnt         <= '0;
         tx_data     <= '0;
         grant       <= '0;
         req_ack     <= '0;
         tx_wr       <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         lock        <= lock_d;
         cnt         <= cnt_d;
         tx_data     <= tx_data_d;
         grant       <= grant_d;
         req_ack     <= ack_d;
         tx_wr       <= wr_d;
         busy        <= (state_d != IDLE);
         err_timeout <= err_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. A UART core model answers each
//   tx_wr with BUSY_LEN cycles of tx_busy (can be disabled to provoke a
//   timeout, or overridden with force_busy). Service order and transmitted
//   bytes are predicted by a queue-level round-robin/lock model.
module tb_uart_tx_arbiter;
   localparam int NREQ     = 4;
   localparam int TO       = 16;
   localparam int BUSY_LEN = 10;
   localparam int BUDGET   = 800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_lock  = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_ack, grant;
   logic [7:0]  tx_data;
   logic        tx_wr, busy, err_timeout;
   logic        tx_busy;
   logic        err_clr = 1'b0;

   uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(TO), .IDX_W(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
      .req_data(req_data), .req_ack(req_ack), .grant(grant), .tx_data(tx_data),
      .tx_wr(tx_wr), .tx_busy(tx_busy), .busy(busy), .err_timeout(err_timeout),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   // UART core model
   int   core_cnt   = 0;
   logic core_en    = 1'b1;
   logic force_busy = 1'b0;
   always @(posedge clk or negedge rst) begin
      if (!rst)               core_cnt <= 0;
      else if (core_cnt > 0)  core_cnt <= core_cnt - 1;
      else if (tx_wr && core_en) core_cnt <= BUSY_LEN;
   end
   assign tx_busy = (core_cnt != 0) || force_busy;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int   model_ptr  = NREQ - 1;
   logic model_lock = 1'b0;

   int         n_q [NREQ];
   logic [7:0] d_q [NREQ][8];
   logic       l_q [NREQ][8];
   int         act_order[$];
   logic [7:0] act_bytes[$];
   int         exp_order[$];
   logic [7:0] exp_bytes[$];

   function automatic int model_arb(input logic [3:0] v);
      int w;
      w = -1;
      if (model_lock && v[model_ptr]) w = model_ptr;
      else
         for (int k = 1; k <= NREQ; k++)
            if (w < 0 && v[(model_ptr + k) % NREQ]) w = (model_ptr + k) % NREQ;
      model_ptr = w;
      return w;
   endfunction

   task automatic build_expected();
      int h [NREQ];
      logic [3:0] v;
      int w;
      exp_order.delete();
      exp_bytes.delete();
      for (int i = 0; i < NREQ; i++) h[i] = 0;
      while (1) begin
         v = '0;
         for (int i = 0; i < NREQ; i++) v[i] = (h[i] < n_q[i]);
         if (v == 4'b0000) break;
         w = model_arb(v);
         exp_order.push_back(w);
         exp_bytes.push_back(d_q[w][h[w]]);
         model_lock = l_q[w][h[w]];
         h[w]++;
      end
   endtask

   function automatic bit orders_equal();
      if (act_order.size() != exp_order.size()) return 0;
      foreach (act_order[i]) if (act_order[i] != exp_order[i]) return 0;
      return 1;
   endfunction

   function automatic bit bytes_equal();
      if (act_bytes.size() != exp_bytes.size()) return 0;
      foreach (act_bytes[i]) if (act_bytes[i] !== exp_bytes[i]) return 0;
      return 1;
   endfunction

   function automatic string fmt_q(input int q[$]);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
      return s;
   endfunction

   function automatic string fmt_b(input logic [7:0] q[$]);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   // Presents queued bytes (each requester holds its head until acked) and
   // records ack order and written bytes until everything drains.
   task automatic run_traffic(output logic ok_onehot, output logic timed_out);
      int h [NREQ];
      int cyc;
      logic pending;
      act_order.delete();
      act_bytes.delete();
      for (int i = 0; i < NREQ; i++) h[i] = 0;
      ok_onehot = 1'b1;
      cyc = 0;
      pending = 1'b1;
      while (cyc < BUDGET && (pending || busy)) begin
         for (int i = 0; i < NREQ; i++) begin
            if (h[i] < n_q[i]) begin
               req_valid[i] = 1'b1;
               req_lock[i]  = l_q[i][h[i]];
               req_data[8*i +: 8] = d_q[i][h[i]];
            end else begin
               req_valid[i] = 1'b0;
               req_lock[i]  = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
         if (req_ack != 4'b0000) begin
            if ($countones(req_ack) != 1 || grant != req_ack) ok_onehot = 1'b0;
            for (int i = 0; i < NREQ; i++)
               if (req_ack[i]) begin act_order.push_back(i); h[i]++; end
         end
         if (tx_wr) act_bytes.push_back(tx_data);
         pending = 1'b0;
         for (int i = 0; i < NREQ; i++) if (h[i] < n_q[i]) pending = 1'b1;
      end
      req_valid = '0;
      req_lock  = '0;
      timed_out = (cyc >= BUDGET);
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while (busy !== 1'b0 && c < 200) begin @(negedge clk); c++; end
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL %s_idle_wait: busy=%b, required 0 within 200 cycles", name, busy);
         errors++;
      end
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NREQ; i++) n_q[i] = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({req_ack, grant, tx_data, tx_wr, busy, err_timeout} !== '0) begin
         $display("FAIL reset_hold: ack=%b grant=%b data=%h wr=%b busy=%b err=%b, required all 0",
                  req_ack, grant, tx_data, tx_wr, busy, err_timeout);
         errors++;
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({req_ack, grant, tx_data, tx_wr, busy, err_timeout} !== '0) begin
         $display("FAIL reset_release: ack=%b grant=%b data=%h wr=%b busy=%b err=%b, required all 0",
                  req_ack, grant, tx_data, tx_wr, busy, err_timeout);
         errors++;
      end
      model_ptr  = NREQ - 1;
      model_lock = 1'b0;
   endtask

   task automatic test_round_robin();
      logic ok, to;
      clear_queues();
      n_q = '{2, 1, 1, 1};
      d_q[0][0] = 8'h10; d_q[0][1] = 8'h11; d_q[1][0] = 8'h21;
      d_q[2][0] = 8'h32; d_q[3][0] = 8'h43;
      for (int i = 0; i < NREQ; i++) begin l_q[i][0] = 1'b0; l_q[i][1] = 1'b0; end
      build_expected();
      run_traffic(ok, to);
      checks++;
      if (to) begin $display("FAIL rr_budget: transfers did not finish in %0d cycles", BUDGET); errors++; end
      checks++;
      if (!orders_equal()) begin
         $display("FAIL rr_order: got %s required %s", fmt_q(act_order), fmt_q(exp_order)); errors++;
      end
      checks++;
      if (!ok) begin $display("FAIL rr_onehot: ack/grant not matching one-hot, required one-hot equal"); errors++; end
      checks++;
      if (!bytes_equal()) begin
         $display("FAIL rr_bytes: got %s required %s", fmt_b(act_bytes), fmt_b(exp_bytes)); errors++;
      end
      checks++;
      if (grant !== 4'b0001) begin $display("FAIL rr_grant_hold: got %b required 0001", grant); errors++; end
   endtask

   task automatic test_lock();
      logic ok, to;
      clear_queues();
      n_q = '{0, 3, 1, 0};
      d_q[1][0] = 8'hB0; d_q[1][1] = 8'hB1; d_q[1][2] = 8'hB2; d_q[2][0] = 8'hC0;
      l_q[1][0] = 1'b1; l_q[1][1] = 1'b1; l_q[1][2] = 1'b0; l_q[2][0] = 1'b0;
      build_expected();
      run_traffic(ok, to);
      checks++;
      if (to || !orders_equal()) begin
         $display("FAIL lock_order: got %s required %s (timeout=%b)", fmt_q(act_order), fmt_q(exp_order), to);
         errors++;
      end
      checks++;
      if (!bytes_equal()) begin
         $display("FAIL lock_bytes: got %s required %s", fmt_b(act_bytes), fmt_b(exp_bytes)); errors++;
      end
   endtask

   task automatic test_single();
      req_data = $urandom;
      req_data[23:16] = 8'hA5;
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b0100 || tx_wr !== 1'b0) begin
         $display("FAIL single_ack: ack=%b wr=%b, required ack=0100 wr=0", req_ack, tx_wr); errors++;
      end
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b0000 || tx_wr !== 1'b1 || tx_data !== 8'hA5) begin
         $display("FAIL single_wr: ack=%b wr=%b data=%h, required ack=0000 wr=1 data=a5", req_ack, tx_wr, tx_data);
         errors++;
      end
      @(negedge clk);
      checks++;
      if (tx_wr !== 1'b0) begin $display("FAIL single_wr_pulse: wr=%b required 0", tx_wr); errors++; end
      wait_idle("single");
      checks++;
      if (grant !== 4'b0100 || tx_data !== 8'hA5) begin
         $display("FAIL single_hold: grant=%b data=%h required grant=0100 data=a5", grant, tx_data); errors++;
      end
      void'(model_arb(4'b0100));
      model_lock = 1'b0;
   endtask

   task automatic test_core_busy();
      logic seen;
      force_busy = 1'b1;
      req_data[7:0] = 8'h5A;
      req_valid = 4'b0001;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (req_ack != 4'b0000 || tx_wr) seen = 1'b1;
      end
      checks++;
      if (seen || busy !== 1'b0) begin
         $display("FAIL core_busy_hold: activity=%b busy=%b, required no ack/wr and busy=0", seen, busy); errors++;
      end
      force_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b0001) begin $display("FAIL core_busy_ack: got %b required 0001", req_ack); errors++; end
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (tx_wr !== 1'b1 || tx_data !== 8'h5A) begin
         $display("FAIL core_busy_wr: wr=%b data=%h required wr=1 data=5a", tx_wr, tx_data); errors++;
      end
      wait_idle("core_busy");
      void'(model_arb(4'b0001));
      model_lock = 1'b0;
   endtask

   task automatic test_random();
      logic ok, to;
      for (int r = 0; r < 5; r++) begin
         clear_queues();
         for (int i = 0; i < NREQ; i++) begin
            n_q[i] = $urandom_range(0, 3);
            for (int j = 0; j < 8; j++) begin
               d_q[i][j] = 8'($urandom);
               l_q[i][j] = ($urandom_range(0, 2) == 0);
            end
         end
         if (n_q[0] + n_q[1] + n_q[2] + n_q[3] == 0) n_q[r % NREQ] = 2;
         build_expected();
         run_traffic(ok, to);
         checks++;
         if (to || !orders_equal()) begin
            $display("FAIL random%0d_order: got %s required %s (timeout=%b)", r, fmt_q(act_order), fmt_q(exp_order), to);
            errors++;
         end
         checks++;
         if (!bytes_equal() || !ok) begin
            $display("FAIL random%0d_bytes: got %s required %s (onehot_ok=%b)", r, fmt_b(act_bytes), fmt_b(exp_bytes), ok);
            errors++;
         end
      end
   endtask

   task automatic test_timeout();
      logic ok, to;
      core_en = 1'b0;
      req_data[31:24] = 8'h3C;
      req_lock  = 4'b1000;
      req_valid = 4'b1000;
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b1000) begin $display("FAIL to_ack: got %b required 1000", req_ack); errors++; end
      req_valid = '0;
      req_lock  = '0;
      @(negedge clk);
      checks++;
      if (tx_wr !== 1'b1) begin $display("FAIL to_wr: got %b required 1", tx_wr); errors++; end
      repeat (TO - 1) @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL to_early: err=%b busy=%b required err=0 busy=1", err_timeout, busy); errors++;
      end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL to_set: err=%b busy=%b required err=1 busy=0", err_timeout, busy); errors++;
      end
      void'(model_arb(4'b1000));
      model_lock = 1'b0;

      // Next request still served; the timed-out lock must not persist.
      core_en = 1'b1;
      clear_queues();
      n_q = '{1, 0, 0, 1};
      d_q[0][0] = 8'h0D; d_q[3][0] = 8'h3D; l_q[0][0] = 1'b0; l_q[3][0] = 1'b0;
      build_expected();
      run_traffic(ok, to);
      checks++;
      if (to || !orders_equal() || !bytes_equal()) begin
         $display("FAIL to_after: order %s bytes %s required order %s bytes %s",
                  fmt_q(act_order), fmt_b(act_bytes), fmt_q(exp_order), fmt_b(exp_bytes));
         errors++;
      end
      checks++;
      if (err_timeout !== 1'b1) begin $display("FAIL to_sticky: got %b required 1", err_timeout); errors++; end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin $display("FAIL to_clear: got %b required 0", err_timeout); errors++; end

      // Timeout and clear on the same edge: set wins.
      core_en = 1'b0;
      req_data[15:8] = 8'h77;
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      repeat (TO - 1) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1) begin $display("FAIL to_set_wins: got %b required 1", err_timeout); errors++; end
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin $display("FAIL to_clear2: got %b required 0", err_timeout); errors++; end
      void'(model_arb(4'b0010));
      model_lock = 1'b0;
      core_en = 1'b1;
   endtask

   task automatic test_async_reset();
      logic ok, to;
      req_data[15:8] = 8'h81;
      req_lock  = 4'b0010;
      req_valid = 4'b0010;
      @(negedge clk);
      req_valid = '0;
      req_lock  = '0;
      repeat (4) @(negedge clk);
      checks++;
      if (tx_busy !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL arst_setup: tx_busy=%b busy=%b required both 1", tx_busy, busy); errors++;
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({req_ack, grant, tx_data, tx_wr, busy, err_timeout} !== '0) begin
         $display("FAIL arst_outputs: ack=%b grant=%b data=%h wr=%b busy=%b err=%b, required all 0",
                  req_ack, grant, tx_data, tx_wr, busy, err_timeout);
         errors++;
      end
      @(negedge clk);
      rst = 1'b1;
      model_ptr  = NREQ - 1;
      model_lock = 1'b0;
      clear_queues();
      n_q = '{1, 1, 1, 1};
      for (int i = 0; i < NREQ; i++) begin d_q[i][0] = 8'(8'hE0 + i); l_q[i][0] = 1'b0; end
      build_expected();
      run_traffic(ok, to);
      checks++;
      if (to || !orders_equal() || !bytes_equal()) begin
         $display("FAIL arst_rearb: order %s bytes %s required order %s bytes %s",
                  fmt_q(act_order), fmt_b(act_bytes), fmt_q(exp_order), fmt_b(exp_bytes));
         errors++;
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_lock();
      test_single();
      test_core_busy();
      test_random();
      test_timeout();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
